// File: rtl/demux1to2_32.sv
// demux1to2_32: 1-to-2 valid/ready word demultiplexer, one FIFO per output so a stalled sink never blocks the other
module demux1to2_32 #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [15:0]      a_cnt,
    output logic [15:0]      b_cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [1:0][WIDTH-1:0] w_data;
    logic [1:0][15:0]      w_cnt;
    logic [1:0]            w_valid;
    logic [1:0]            w_full;
    logic [1:0]            w_rdy;

    assign w_rdy    = {b_ready, a_ready};
    assign in_ready = in_sel ? !w_full[1] : !w_full[0];

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        logic [WIDTH-1:0] r_mem [DEPTH];
        logic [AW:0]      r_rd, r_wr, r_cnt;
        logic [15:0]      r_dcnt;
        logic             w_push, w_pop;

        assign w_push     = in_valid && in_ready && (in_sel == 1'(g));
        assign w_pop      = w_valid[g] && w_rdy[g];
        assign w_valid[g] = (r_cnt != '0);
        assign w_full[g]  = (r_cnt == (AW+1)'(DEPTH));
        assign w_data[g]  = r_mem[r_rd[AW-1:0]];
        assign w_cnt[g]   = r_dcnt;

        // pointers use only their low AW bits as the slot index, so they wrap modulo DEPTH
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rd   <= '0;
                r_wr   <= '0;
                r_cnt  <= '0;
                r_dcnt <= '0;
                for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
            end else begin
                if (w_push) r_mem[r_wr[AW-1:0]] <= in_data;
                r_wr   <= r_wr + (AW+1)'(w_push);
                r_rd   <= r_rd + (AW+1)'(w_pop);
                r_cnt  <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
                r_dcnt <= r_dcnt + 16'(w_pop);
            end
        end
    end

    assign a_data  = w_data[0];
    assign b_data  = w_data[1];
    assign a_valid = w_valid[0];
    assign b_valid = w_valid[1];
    assign a_cnt   = w_cnt[0];
    assign b_cnt   = w_cnt[1];
endmodule

// File: tb/tb_demux1to2_32.sv
// tb_demux1to2_32: directed self-checking bench for demux1to2_32
module tb_demux1to2_32;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_sel, in_valid, in_ready;
    logic [31:0] a_data, b_data;
    logic        a_valid, a_ready, b_valid, b_ready;
    logic [15:0] a_cnt, b_cnt;
    int          n_cmp = 0;
    int          n_err = 0;
    int          stalls;
    logic [31:0] got;

    demux1to2_32 dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
        .a_cnt(a_cnt), .b_cnt(b_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_data = '0; in_sel = 1'b0; in_valid = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
        // reset values
        tick(); tick();
        chk("rst_a_valid", 32'(a_valid), 0);
        chk("rst_b_valid", 32'(b_valid), 0);
        chk("rst_a_data", a_data, 0);
        chk("rst_b_data", b_data, 0);
        chk("rst_a_cnt", 32'(a_cnt), 0);
        chk("rst_b_cnt", 32'(b_cnt), 0);
        chk("rst_ready_sel0", 32'(in_ready), 1);
        in_sel = 1'b1; #1;
        chk("rst_ready_sel1", 32'(in_ready), 1);
        rst_n = 1'b1; in_sel = 1'b0;
        // single route
        in_data = 32'hDEADBEEF; in_valid = 1'b1; a_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("single_a_valid", 32'(a_valid), 1);
        chk("single_a_data", a_data, 32'hDEADBEEF);
        chk("single_b_valid", 32'(b_valid), 0);
        chk("single_a_cnt_pre", 32'(a_cnt), 0);
        tick();
        chk("single_a_cnt", 32'(a_cnt), 1);
        chk("single_a_empty", 32'(a_valid), 0);
        // isolation: stalled B fills, A still flows
        in_sel = 1'b1; in_valid = 1'b1; in_data = 32'h1;
        tick();
        in_data = 32'h2;
        tick();
        chk("iso_b_full_ready", 32'(in_ready), 0);
        chk("iso_b_head", b_data, 32'h1);
        in_sel = 1'b0; in_data = 32'h3; #1;
        chk("iso_a_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        chk("iso_a_valid", 32'(a_valid), 1);
        chk("iso_a_data", a_data, 32'h3);
        tick();
        chk("iso_a_cnt", 32'(a_cnt), 2);
        b_ready = 1'b1; in_sel = 1'b1; #1;
        chk("iso_b_first", b_data, 32'h1);
        tick();
        chk("iso_b_second", b_data, 32'h2);
        chk("iso_b_ready_back", 32'(in_ready), 1);
        chk("iso_b_cnt1", 32'(b_cnt), 1);
        tick();
        chk("iso_b_cnt2", 32'(b_cnt), 2);
        chk("iso_b_empty", 32'(b_valid), 0);
        // streaming, alternating destination
        stalls = 0;
        for (int i = 0; i < 100; i++) begin
            in_sel = i[0]; in_data = 32'h1000 + 32'(i); in_valid = 1'b1;
            #1;
            if (!in_ready) stalls++;
            tick();
            got = i[0] ? b_data : a_data;
            chk("stream_order", got, 32'h1000 + 32'(i));
        end
        in_valid = 1'b0;
        tick();
        chk("stream_stalls", 32'(stalls), 0);
        chk("stream_a_cnt", 32'(a_cnt), 52);
        chk("stream_b_cnt", 32'(b_cnt), 52);
        // counter wrap on A
        in_sel = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 65483; i++) begin
            in_data = 32'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("wrap_a_max", 32'(a_cnt), 32'hFFFF);
        in_valid = 1'b1; in_data = 32'h55;
        tick();
        in_valid = 1'b0;
        tick();
        chk("wrap_a_zero", 32'(a_cnt), 0);
        chk("wrap_b_cnt", 32'(b_cnt), 52);
        // async reset with A full and a push in flight
        a_ready = 1'b0; in_sel = 1'b0; in_valid = 1'b1; in_data = 32'hA1;
        tick();
        in_data = 32'hA2;
        tick();
        chk("mid_a_valid", 32'(a_valid), 1);
        chk("mid_a_full", 32'(in_ready), 0);
        in_sel = 1'b1; in_data = 32'hB1;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_a_valid", 32'(a_valid), 0);
        chk("mid_rst_b_valid", 32'(b_valid), 0);
        chk("mid_rst_a_data", a_data, 0);
        chk("mid_rst_a_cnt", 32'(a_cnt), 0);
        chk("mid_rst_b_cnt", 32'(b_cnt), 0);
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1; a_ready = 1'b1; b_ready = 1'b1;
        tick();
        chk("post_rst_a_valid", 32'(a_valid), 0);
        chk("post_rst_b_valid", 32'(b_valid), 0);
        chk("post_rst_a_data", a_data, 0);
        chk("post_rst_a_cnt", 32'(a_cnt), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
